control_sequencer: RTL and testbench

// - Hardwired control unit for the 32-bit bus datapath. Replaces the hand-sequenced T0..Tn stimulus used in bring-up.
// - Steps a T-state counter and decodes IR[31:27] to drive every datapath control strobe. One strobe set is issued per clock.
// - Sits beside the datapath. Inputs: IR and CON_FF. Outputs: all bus, register-enable and ALU-select lines.

---
 rtl/control_sequencer_pkg.sv | 96 +++++++++
 rtl/control_sequencer_step_counter.sv | 22 ++
 rtl/control_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU selects,
// sequencer modes and the control-strobe bundle.
package control_sequencer_pkg;

    localparam int unsigned STEP_W = 3;

    typedef enum logic [1:0] {
        MODE_RESET = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_HALT  = 2'd2
    } mode_t;

    typedef enum logic [4:0] {
        OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
        OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
        OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHL  = 5'b01000,
        OP_ROR  = 5'b01001, OP_ROL  = 5'b01010, OP_ADDI = 5'b01011,
        OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110,
        OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001,
        OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_JAL  = 5'b10100,
        OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111,
        OP_MFLO = 5'b11000, OP_NOP  = 5'b11001, OP_HALT = 5'b11010
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD = 4'd2,  ALU_SUB = 4'd3,
        ALU_MUL = 4'd4, ALU_DIV = 4'd5, ALU_SHR = 4'd6,  ALU_SHL = 4'd7,
        ALU_ROR = 4'd8, ALU_ROL = 4'd9, ALU_NEG = 4'd10, ALU_NOT = 4'd11
    } alu_op_t;

    typedef struct packed {
        logic    pc_out;
        logic    zhigh_out;
        logic    zlow_out;
        logic    mdr_out;
        logic    high_out;
        logic    low_out;
        logic    in_port_out;
        logic    c_out;
        logic    ba_out;
        logic    r_out;
        logic    mar_in;
        logic    zhigh_in;
        logic    zlow_in;
        logic    high_in;
        logic    low_in;
        logic    pc_in;
        logic    mdr_in;
        logic    ir_in;
        logic    y_in;
        logic    r_in;
        logic    out_port_in;
        logic    con_in;
        logic    gra;
        logic    grb;
        logic    grc;
        logic    inc_pc;
        logic    read;
        logic    ram_enable;
        logic    r15_enable;
        logic    pc_enable;
        alu_op_t control;
    } ctrl_t;

    function automatic alu_op_t alu_op_for(input opcode_t op);
        case (op)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR,  OP_ORI:  return ALU_OR;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            OP_ROR:          return ALU_ROR;
            OP_ROL:          return ALU_ROL;
            OP_MUL:          return ALU_MUL;
            OP_DIV:          return ALU_DIV;
            OP_NEG:          return ALU_NEG;
            OP_NOT:          return ALU_NOT;
            default:         return ALU_AND;
        endcase
    endfunction

    // Index of the final T-state of each instruction; fetch always occupies T0..T2.
    function automatic logic [STEP_W-1:0] last_step(input opcode_t op);
        case (op)
            OP_LD, OP_ST:                           return 3'd7;
            OP_MUL, OP_DIV, OP_BR:                  return 3'd6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_ADDI, OP_ANDI, OP_ORI:               return 3'd5;
            OP_NEG, OP_NOT, OP_JAL:                 return 3'd4;
            default:                                return 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_step_counter.sv
// T-state counter: synchronous active-low clear, load-zero at instruction end,
// otherwise advances one step per clock.
module step_counter
    import control_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              clear_n,
    input  logic              end_of_instr,
    output logic [STEP_W-1:0] step
);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            step <= '0;
        end else if (end_of_instr) begin
            step <= '0;
        end else begin
            step <= step + 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps T-states and decodes IR[31:27] into one
// datapath strobe set per clock.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned MAX_STEP = 7,
    parameter int unsigned ALU_W    = 4
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [31:0]      IR,
    input  logic             CON_FF,
    input  logic             Stop,
    output logic             Run,
    output logic             PCout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             highout,
    output logic             lowout,
    output logic             inPortOut,
    output logic             Cout,
    output logic             BAout,
    output logic             Rout,
    output logic             MARin,
    output logic             Zhighin,
    output logic             Zlowin,
    output logic             highin,
    output logic             lowin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Rin,
    output logic             outPortIn,
    output logic             con_in,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             IncPC,
    output logic             Read,
    output logic             ram_enable,
    output logic             R15_enable,
    output logic             PC_enable,
    output logic [ALU_W-1:0] CONTROL
);

    mode_t             mode;
    mode_t             mode_next;
    opcode_t           opcode;
    logic [STEP_W-1:0] step;
    logic              end_of_instr;
    logic              halt_op;
    ctrl_t             ctl;

    // CON_FF only gates the PC load inside the datapath; operand fields are not decoded here.
    logic unused_inputs;
    assign unused_inputs = ^{CON_FF, IR[26:0]};

    assign opcode  = opcode_t'(IR[31:27]);
    assign halt_op = (step == 3'd3) && (opcode == OP_HALT);

    // Outside RUN the counter is pinned at T0 so leaving RESET always starts a fetch.
    assign end_of_instr = (mode != MODE_RUN)
                       || (step == last_step(opcode))
                       || (step == STEP_W'(MAX_STEP));

    step_counter u_step_counter (
        .clk          (Clock),
        .clear_n      (Clear),
        .end_of_instr (end_of_instr),
        .step         (step)
    );

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            mode <= MODE_RESET;
        end else begin
            mode <= mode_next;
        end
    end

    always_comb begin
        mode_next = mode;
        case (mode)
            MODE_RESET: mode_next = MODE_RUN;
            MODE_RUN: begin
                if (halt_op || (end_of_instr && Stop)) begin
                    mode_next = MODE_HALT;
                end
            end
            MODE_HALT: mode_next = MODE_HALT;
            default:   mode_next = MODE_RESET;
        endcase
    end

    always_comb begin
        ctl = '0;
        if (mode == MODE_RUN) begin
            case (step)
                3'd0: begin
                    ctl.pc_out  = 1'b1;
                    ctl.mar_in  = 1'b1;
                    ctl.inc_pc  = 1'b1;
                    ctl.zlow_in = 1'b1;
                end
                3'd1: begin
                    ctl.zlow_out = 1'b1;
                    ctl.pc_in    = 1'b1;
                    ctl.read     = 1'b1;
                    ctl.mdr_in   = 1'b1;
                end
                3'd2: begin
                    ctl.mdr_out = 1'b1;
                    ctl.ir_in   = 1'b1;
                end
                default: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                        OP_ADDI, OP_ANDI, OP_ORI: begin
                            case (step)
                                3'd3: begin
                                    ctl.grb   = 1'b1;
                                    ctl.r_out = 1'b1;
                                    ctl.y_in  = 1'b1;
                                end
                                3'd4: begin
                                    if (opcode inside {OP_ADDI, OP_ANDI, OP_ORI}) begin
                                        ctl.c_out = 1'b1;
                                    end else begin
                                        ctl.grc   = 1'b1;
                                        ctl.r_out = 1'b1;
                                    end
                                    ctl.control = alu_op_for(opcode);
                                    ctl.zlow_in = 1'b1;
                                end
                                3'd5: begin
                                    ctl.zlow_out = 1'b1;
                                    ctl.gra      = 1'b1;
                                    ctl.r_in     = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        OP_NEG, OP_NOT: begin
                            case (step)
                                3'd3: begin
                                    ctl.grb     = 1'b1;
                                    ctl.r_out   = 1'b1;
                                    ctl.control = alu_op_for(opcode);
                                    ctl.zlow_in = 1'b1;
                                end
                                3'd4: begin
                                    ctl.zlow_out = 1'b1;
                                    ctl.gra      = 1'b1;
                                    ctl.r_in     = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        OP_MUL, OP_DIV: begin
                            case (step)
                                3'd3: begin
                                    ctl.gra   = 1'b1;
                                    ctl.r_out = 1'b1;
                                    ctl.y_in  = 1'b1;
                                end
                                3'd4: begin
                                    ctl.grb      = 1'b1;
                                    ctl.r_out    = 1'b1;
                                    ctl.control  = alu_op_for(opcode);
                                    ctl.zhigh_in = 1'b1;
                                    ctl.zlow_in  = 1'b1;
                                end
                                3'd5: begin
                                    ctl.zlow_out = 1'b1;
                                    ctl.low_in   = 1'b1;
                                end
                                3'd6: begin
                                    ctl.zhigh_out = 1'b1;
                                    ctl.high_in   = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        OP_LD, OP_LDI, OP_ST: begin
                            case (step)
                                3'd3: begin
                                    ctl.grb    = 1'b1;
                                    ctl.ba_out = 1'b1;
                                    ctl.y_in   = 1'b1;
                                end
                                3'd4: begin
                                    ctl.c_out   = 1'b1;
                                    ctl.control = ALU_ADD;
                                    ctl.zlow_in = 1'b1;
                                end
                                3'd5: begin
                                    ctl.zlow_out = 1'b1;
                                    if (opcode == OP_LDI) begin
                                        ctl.gra  = 1'b1;
                                        ctl.r_in = 1'b1;
                                    end else begin
                                        ctl.mar_in = 1'b1;
                                    end
                                end
                                3'd6: begin
                                    ctl.mdr_in = 1'b1;
                                    if (opcode == OP_ST) begin
                                        ctl.gra   = 1'b1;
                                        ctl.r_out = 1'b1;
                                    end else begin
                                        ctl.read = 1'b1;
                                    end
                                end
                                3'd7: begin
                                    if (opcode == OP_ST) begin
                                        ctl.ram_enable = 1'b1;
                                    end else begin
                                        ctl.mdr_out = 1'b1;
                                        ctl.gra     = 1'b1;
                                        ctl.r_in    = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        OP_BR: begin
                            case (step)
                                3'd3: begin
                                    ctl.gra    = 1'b1;
                                    ctl.r_out  = 1'b1;
                                    ctl.con_in = 1'b1;
                                end
                                3'd4: begin
                                    ctl.pc_out = 1'b1;
                                    ctl.y_in   = 1'b1;
                                end
                                3'd5: begin
                                    ctl.c_out   = 1'b1;
                                    ctl.control = ALU_ADD;
                                    ctl.zlow_in = 1'b1;
                                end
                                3'd6: begin
                                    ctl.zlow_out  = 1'b1;
                                    ctl.pc_enable = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        OP_JR: begin
                            if (step == 3'd3) begin
                                ctl.gra   = 1'b1;
                                ctl.r_out = 1'b1;
                                ctl.pc_in = 1'b1;
                            end
                        end
                        OP_JAL: begin
                            if (step == 3'd3) begin
                                ctl.pc_out     = 1'b1;
                                ctl.r15_enable = 1'b1;
                                ctl.r_in       = 1'b1;
                            end else if (step == 3'd4) begin
                                ctl.gra   = 1'b1;
                                ctl.r_out = 1'b1;
                                ctl.pc_in = 1'b1;
                            end
                        end
                        OP_IN: begin
                            if (step == 3'd3) begin
                                ctl.in_port_out = 1'b1;
                                ctl.gra         = 1'b1;
                                ctl.r_in        = 1'b1;
                            end
                        end
                        OP_OUT: begin
                            if (step == 3'd3) begin
                                ctl.gra         = 1'b1;
                                ctl.r_out       = 1'b1;
                                ctl.out_port_in = 1'b1;
                            end
                        end
                        OP_MFHI: begin
                            if (step == 3'd3) begin
                                ctl.high_out = 1'b1;
                                ctl.gra      = 1'b1;
                                ctl.r_in     = 1'b1;
                            end
                        end
                        OP_MFLO: begin
                            if (step == 3'd3) begin
                                ctl.low_out = 1'b1;
                                ctl.gra     = 1'b1;
                                ctl.r_in    = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign Run        = (mode == MODE_RUN);
    assign PCout      = ctl.pc_out;
    assign Zhighout   = ctl.zhigh_out;
    assign Zlowout    = ctl.zlow_out;
    assign MDRout     = ctl.mdr_out;
    assign highout    = ctl.high_out;
    assign lowout     = ctl.low_out;
    assign inPortOut  = ctl.in_port_out;
    assign Cout       = ctl.c_out;
    assign BAout      = ctl.ba_out;
    assign Rout       = ctl.r_out;
    assign MARin      = ctl.mar_in;
    assign Zhighin    = ctl.zhigh_in;
    assign Zlowin     = ctl.zlow_in;
    assign highin     = ctl.high_in;
    assign lowin      = ctl.low_in;
    assign PCin       = ctl.pc_in;
    assign MDRin      = ctl.mdr_in;
    assign IRin       = ctl.ir_in;
    assign Yin        = ctl.y_in;
    assign Rin        = ctl.r_in;
    assign outPortIn  = ctl.out_port_in;
    assign con_in     = ctl.con_in;
    assign Gra        = ctl.gra;
    assign Grb        = ctl.grb;
    assign Grc        = ctl.grc;
    assign IncPC      = ctl.inc_pc;
    assign Read       = ctl.read;
    assign ram_enable = ctl.ram_enable;
    assign R15_enable = ctl.r15_enable;
    assign PC_enable  = ctl.pc_enable;
    assign CONTROL    = ALU_W'(ctl.control);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instruction sequences push
// hand-derived strobe sets per cycle; a negedge monitor pops and compares.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] IR    = '0;
    logic        CON_FF = 1'b0;
    logic        Stop  = 1'b0;
    logic        Run, PCout, Zhighout, Zlowout, MDRout, highout, lowout, inPortOut, Cout, BAout, Rout;
    logic        MARin, Zhighin, Zlowin, highin, lowin, PCin, MDRin, IRin, Yin, Rin, outPortIn, con_in;
    logic        Gra, Grb, Grc, IncPC, Read, ram_enable, R15_enable, PC_enable;
    logic [3:0]  CONTROL;

    control_sequencer #(.MAX_STEP(7), .ALU_W(4)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .highout(highout), .lowout(lowout), .inPortOut(inPortOut), .Cout(Cout),
        .BAout(BAout), .Rout(Rout), .MARin(MARin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .highin(highin), .lowin(lowin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Rin(Rin), .outPortIn(outPortIn), .con_in(con_in), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .ram_enable(ram_enable),
        .R15_enable(R15_enable), .PC_enable(PC_enable), .CONTROL(CONTROL)
    );

    always #5 Clock = ~Clock;

    typedef logic [34:0] obs_t;
    localparam obs_t RUN = obs_t'(1) << 34;
    localparam obs_t PCOUT = obs_t'(1) << 29, ZHIGHOUT = obs_t'(1) << 28, ZLOWOUT = obs_t'(1) << 27;
    localparam obs_t MDROUT = obs_t'(1) << 26, HIGHOUT = obs_t'(1) << 25, LOWOUT = obs_t'(1) << 24;
    localparam obs_t INPORTOUT = obs_t'(1) << 23, COUT = obs_t'(1) << 22, BAOUT = obs_t'(1) << 21;
    localparam obs_t ROUT = obs_t'(1) << 20, MARIN = obs_t'(1) << 19, ZHIGHIN = obs_t'(1) << 18;
    localparam obs_t ZLOWIN = obs_t'(1) << 17, HIGHIN = obs_t'(1) << 16, LOWIN = obs_t'(1) << 15;
    localparam obs_t PCIN = obs_t'(1) << 14, MDRIN = obs_t'(1) << 13, IRIN = obs_t'(1) << 12;
    localparam obs_t YIN = obs_t'(1) << 11, RIN = obs_t'(1) << 10, OUTPORTIN = obs_t'(1) << 9;
    localparam obs_t CONIN = obs_t'(1) << 8, GRA = obs_t'(1) << 7, GRB = obs_t'(1) << 6;
    localparam obs_t GRC = obs_t'(1) << 5, INCPC = obs_t'(1) << 4, READ = obs_t'(1) << 3;
    localparam obs_t RAMEN = obs_t'(1) << 2, R15EN = obs_t'(1) << 1, PCEN = obs_t'(1);

    function automatic obs_t alu(input int unsigned v);
        return obs_t'(v) << 30;
    endfunction

    obs_t  observed;
    assign observed = {Run, CONTROL, PCout, Zhighout, Zlowout, MDRout, highout, lowout,
                       inPortOut, Cout, BAout, Rout, MARin, Zhighin, Zlowin, highin, lowin,
                       PCin, MDRin, IRin, Yin, Rin, outPortIn, con_in, Gra, Grb, Grc,
                       IncPC, Read, ram_enable, R15_enable, PC_enable};

    obs_t  exp_q[$];
    string name_q[$];
    int    total  = 0;
    int    passed = 0;

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            if (observed === e) passed++;
            else $display("FAIL %s: got %h expected %h", n, observed, e);
        end
    end

    // Inputs for the cycle are set before calling; the expectation covers that cycle.
    task automatic chk(input obs_t e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge Clock);
        #1;
    endtask

    task automatic run_chk(input obs_t e, input string n);
        chk(e | RUN, n);
    endtask

    task automatic fetch(input string n);
        run_chk(PCOUT | MARIN | INCPC | ZLOWIN, {n, "_T0"});
        run_chk(ZLOWOUT | PCIN | READ | MDRIN, {n, "_T1"});
        run_chk(MDROUT | IRIN, {n, "_T2"});
    endtask

    task automatic rtype(input logic [31:0] ir, input obs_t op, input string n);
        IR = ir;
        fetch(n);
        run_chk(GRB | ROUT | YIN, {n, "_T3"});
        run_chk(GRC | ROUT | op | ZLOWIN, {n, "_T4"});
        run_chk(ZLOWOUT | GRA | RIN, {n, "_T5"});
    endtask

    initial begin
        @(posedge Clock); #1;
        chk('0, "reset_hold0");
        chk('0, "reset_hold1");
        Clear = 1'b1;
        chk('0, "reset_exit");

        // ld interrupted by Clear at T5
        IR = 32'h00800000;
        fetch("ld");
        run_chk(GRB | BAOUT | YIN, "ld_T3");
        run_chk(COUT | alu(2) | ZLOWIN, "ld_T4");
        Clear = 1'b0;
        run_chk(ZLOWOUT | MARIN, "ld_T5_clear");
        chk('0, "midclear0");
        chk('0, "midclear1");
        Clear = 1'b1;
        chk('0, "midclear_release");

        // branch
        IR = 32'h91000023;
        CON_FF = 1'b1;
        fetch("br");
        run_chk(GRA | ROUT | CONIN, "br_T3");
        run_chk(PCOUT | YIN, "br_T4");
        run_chk(COUT | alu(2) | ZLOWIN, "br_T5");
        run_chk(ZLOWOUT | PCEN, "br_T6");
        CON_FF = 1'b0;

        // add with Stop pulsed away from the boundary
        IR = 32'h18A20000;
        fetch("add");
        Stop = 1'b1;
        run_chk(GRB | ROUT | YIN, "add_T3");
        run_chk(GRC | ROUT | alu(2) | ZLOWIN, "add_T4");
        Stop = 1'b0;
        run_chk(ZLOWOUT | GRA | RIN, "add_T5");

        // st
        IR = 32'h10800055;
        fetch("st");
        run_chk(GRB | BAOUT | YIN, "st_T3");
        run_chk(COUT | alu(2) | ZLOWIN, "st_T4");
        run_chk(ZLOWOUT | MARIN, "st_T5");
        run_chk(GRA | ROUT | MDRIN, "st_T6");
        run_chk(RAMEN, "st_T7");

        // mul then mfhi
        IR = 32'h70000000;
        fetch("mul");
        run_chk(GRA | ROUT | YIN, "mul_T3");
        run_chk(GRB | ROUT | alu(4) | ZHIGHIN | ZLOWIN, "mul_T4");
        run_chk(ZLOWOUT | LOWIN, "mul_T5");
        run_chk(ZHIGHOUT | HIGHIN, "mul_T6");
        IR = 32'hB8000000;
        fetch("mfhi");
        run_chk(HIGHOUT | GRA | RIN, "mfhi_T3");

        rtype(32'h38000000, alu(6), "shr");

        IR = 32'h80000000;
        fetch("neg");
        run_chk(GRB | ROUT | alu(10) | ZLOWIN, "neg_T3");
        run_chk(ZLOWOUT | GRA | RIN, "neg_T4");

        IR = 32'h08000000;
        fetch("ldi");
        run_chk(GRB | BAOUT | YIN, "ldi_T3");
        run_chk(COUT | alu(2) | ZLOWIN, "ldi_T4");
        run_chk(ZLOWOUT | GRA | RIN, "ldi_T5");

        IR = 32'hA0000000;
        fetch("jal");
        run_chk(PCOUT | R15EN | RIN, "jal_T3");
        run_chk(GRA | ROUT | PCIN, "jal_T4");

        IR = 32'hF8000000;
        fetch("illegal");
        run_chk('0, "illegal_T3");

        // Stop at the boundary of add
        IR = 32'h18A20000;
        fetch("stopadd");
        run_chk(GRB | ROUT | YIN, "stopadd_T3");
        run_chk(GRC | ROUT | alu(2) | ZLOWIN, "stopadd_T4");
        Stop = 1'b1;
        run_chk(ZLOWOUT | GRA | RIN, "stopadd_T5");
        chk('0, "stop_halt0");
        Stop = 1'b0;
        for (int i = 0; i < 4; i++) chk('0, "stop_halt");
        Clear = 1'b0;
        chk('0, "halt_clear");
        Clear = 1'b1;
        chk('0, "halt_release");

        // halt opcode
        IR = 32'hD0000000;
        fetch("halt");
        run_chk('0, "halt_T3");
        for (int i = 0; i < 20; i++) chk('0, "halted");

        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
